// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: turns SET/CLEAR/TOGGLE/NOP commands into s/r pulses
// of cmd_hold+1 cycles, each followed by GAP_CYC cycles of s=r=0.
// Ports: clk, reset (async, high); cmd_valid/cmd_ready/cmd_op/cmd_hold
// command handshake; q_fb flip-flop readback; s, r registered pulses;
// busy = active or queued.
// Define SR_SEQ_FIFO_EN for a FIFO_DEPTH-entry command FIFO.
module sr_cmd_sequencer #(
  parameter int HOLD_W     = 4,
  parameter int GAP_CYC    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              q_fb,
  output logic              s,
  output logic              r,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  localparam logic [3:0] GAP_LD =
    4'(GAP_CYC - 1);

  if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_gap_chk
    $error("GAP_CYC must be 1..15");
  end

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_fd_chk
    $error("FIFO_DEPTH must be pow2 >= 2");
  end

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [3:0]        gap_cnt;
  logic [3:0]        gap_nxt;
  logic              pol_q;
  logic              pol_nxt;
  logic              s_nxt;
  logic              r_nxt;

  logic              hd_valid;
  logic [1:0]        hd_op;
  logic [HOLD_W-1:0] hd_hold;
  logic              queued;
  logic              take;
  logic              fire;
  logic              fire_pol;

  // Head command is consumed only in IDLE.
  assign take = (state == IDLE) && hd_valid;
  assign fire = take && (hd_op != OP_NOP);

`ifdef SR_SEQ_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]        mem_op   [FIFO_DEPTH];
  logic [HOLD_W-1:0] mem_hold [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              push;
  logic              pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign push     = cmd_valid && !full;
  assign pop      = take;
  assign hd_valid = (count != '0);
  assign hd_op    = mem_op[rd_ptr];
  assign hd_hold  = mem_hold[rd_ptr];
  assign queued   = hd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= cmd_op;
      mem_hold[wr_ptr] <= cmd_hold;
    end
  end
`else
  assign hd_valid = cmd_valid;
  assign hd_op    = cmd_op;
  assign hd_hold  = cmd_hold;
  assign queued   = 1'b0;
`endif

  // TOGGLE picks the polarity that flips q.
  always_comb begin
    fire_pol = 1'b0;
    unique case (1'b1)
      (hd_op == OP_SET): fire_pol = 1'b1;
      (hd_op == OP_TGL): fire_pol = ~q_fb;
      default:           fire_pol = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      pol_q    <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      pol_q    <= pol_nxt;
      s        <= s_nxt;
      r        <= r_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    pol_nxt   = pol_q;
    unique case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = DRIVE;
          hold_nxt  = hd_hold;
          pol_nxt   = fire_pol;
        end
      end
      DRIVE: begin
        if (hold_cnt == '0) begin
          state_nxt = GAP;
          gap_nxt   = GAP_LD;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0)
          state_nxt = IDLE;
        else
          gap_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // s/r register the upcoming state, so they
  // track DRIVE exactly and can never both be 1.
  always_comb begin
    s_nxt = 1'b0;
    r_nxt = 1'b0;
    if (state_nxt == DRIVE) begin
      s_nxt = pol_nxt;
      r_nxt = ~pol_nxt;
    end
    busy = (state != IDLE) || queued;
`ifdef SR_SEQ_FIFO_EN
    cmd_ready = !full;
`else
    cmd_ready = (state == IDLE);
`endif
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb_sr_cmd_sequencer: directed bench for sr_cmd_sequencer.
// Defaults HOLD_W=4, GAP_CYC=1, FIFO_DEPTH=4.
module tb_sr_cmd_sequencer;

  localparam int HOLD_W = 4;
`ifdef SR_SEQ_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] CLR = 2'b01;
  localparam logic [1:0] SET = 2'b10;
  localparam logic [1:0] TGL = 2'b11;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [HOLD_W-1:0] cmd_hold;
  logic              q_fb;
  logic              s;
  logic              r;
  logic              busy;

  sr_cmd_sequencer #(
    .HOLD_W    (HOLD_W),
    .GAP_CYC   (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_hold (cmd_hold),
    .q_fb     (q_fb),
    .s        (s),
    .r        (r),
    .busy     (busy)
  );

  typedef struct {
    bit pol;
    int len;
    int start;
    int gap;
  } pulse_t;

  pulse_t            pq[$];
  pulse_t            cur;
  int                xq[$];
  logic [1:0]        c_op[$];
  logic [HOLD_W-1:0] c_hold[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int zeros = 1000;
  bit in_pulse = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  // Pulse logger: one entry per s/r pulse,
  // with the count of s=r=0 cycles before it.
  initial forever begin
    @(negedge clk);
    chk("s_and_r", int'(s & r), 0);
    if (s | r) begin
      if (in_pulse && (s != cur.pol)) begin
        pq.push_back(cur);
        in_pulse = 0;
        zeros = 0;
      end
      if (!in_pulse) begin
        in_pulse  = 1;
        cur.pol   = s;
        cur.len   = 1;
        cur.start = cyc;
        cur.gap   = zeros;
      end else begin
        cur.len++;
      end
      zeros = 0;
    end else begin
      if (in_pulse) pq.push_back(cur);
      in_pulse = 0;
      zeros++;
    end
  end

  task automatic add(logic [1:0] op,
                     logic [HOLD_W-1:0] h);
    c_op.push_back(op);
    c_hold.push_back(h);
  endtask

  task automatic drive_all();
    int t;
    xq.delete();
    for (int i = 0; i < c_op.size(); i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = c_op[i];
      cmd_hold  = c_hold[i];
      t = 0;
      while (!cmd_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("xfer_timeout", int'(t >= 200), 0);
      xq.push_back(cyc);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    c_op.delete();
    c_hold.delete();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || in_pulse) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", int'(t >= 300), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run();
    drive_all();
    wait_idle();
  endtask

  task automatic chk_p(string tag, int i,
                       bit pol, int len);
    if (pq.size() > i) begin
      chk({tag, "_pol"}, int'(pq[i].pol), int'(pol));
      chk({tag, "_len"}, pq[i].len, len);
    end else begin
      chk({tag, "_cnt"}, pq.size(), i + 1);
    end
  endtask

  initial begin
    int k;
    int t;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_hold  = '0;
    q_fb      = 1'b0;

    // T1: reset with random valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rst", {s, r, busy, cmd_ready}, 4'b0001);
      cmd_op    = SET;
      cmd_valid = (i == 0) ? 1'b1
                : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("t1_rst", {s, r, busy, cmd_ready}, 4'b0001);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_nopulse", pq.size(), 0);
    chk("t1_idle", {s, r, busy, cmd_ready}, 4'b0001);

    // T2: SET hold=2
    pq.delete();
    q_fb = 1'b0;
    @(negedge clk);
    chk("t2_ready", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = SET;
    cmd_hold  = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (!(s | r) && k < 10) begin
      chk("t2_wait_busy", int'(busy), 1);
      @(negedge clk);
      k++;
    end
    chk("t2_lat", k, LAT);
    for (int i = 0; i < 3; i++) begin
      chk("t2_pulse", {s, r, busy}, 3'b101);
      @(negedge clk);
    end
    chk("t2_gap", {s, r, busy}, 3'b001);
    @(negedge clk);
    chk("t2_idle", {s, r, busy, cmd_ready}, 4'b0001);
    repeat (2) @(negedge clk);

    // T3: TOGGLE resolves from q_fb
    pq.delete();
    q_fb = 1'b1;
    add(TGL, 4'd0);
    run();
    chk("t3a_cnt", pq.size(), 1);
    chk_p("t3a", 0, 1'b0, 1);
    pq.delete();
    q_fb = 1'b0;
    add(TGL, 4'd0);
    run();
    chk("t3b_cnt", pq.size(), 1);
    chk_p("t3b", 0, 1'b1, 1);

    // T4: SET0, CLEAR0, NOP, SET15
    pq.delete();
    add(SET, 4'd0);
    add(CLR, 4'd0);
    add(NOP, 4'd0);
    add(SET, 4'd15);
    run();
    chk("t4_cnt", pq.size(), 3);
    chk_p("t4_p0", 0, 1'b1, 1);
    chk_p("t4_p1", 1, 1'b0, 1);
    chk_p("t4_p2", 2, 1'b1, 16);
    if (pq.size() == 3) begin
      chk("t4_gap1", pq[1].gap, 2);
      chk("t4_gap2", pq[2].gap, 3);
    end

`ifdef SR_SEQ_FIFO_EN
    // T5: fill FIFO behind a long pulse
    pq.delete();
    add(SET, 4'd15);
    add(CLR, 4'd0);
    add(SET, 4'd1);
    add(CLR, 4'd2);
    add(SET, 4'd0);
    add(CLR, 4'd3);
    run();
    chk("t5_cnt", pq.size(), 6);
    chk_p("t5_p0", 0, 1'b1, 16);
    chk_p("t5_p1", 1, 1'b0, 1);
    chk_p("t5_p2", 2, 1'b1, 2);
    chk_p("t5_p3", 3, 1'b0, 3);
    chk_p("t5_p4", 4, 1'b1, 1);
    chk_p("t5_p5", 5, 1'b0, 4);
    chk("t5_fill", xq[4] - xq[0], 4);
    chk("t5_stall", xq[5] - xq[0], 20);
    if (pq.size() == 6)
      chk("t5_popref", xq[5], pq[1].start);
`endif

    // T6: reset in 2nd cycle of SET hold=7
    pq.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = SET;
    cmd_hold  = 4'd7;
    @(negedge clk);
    cmd_op   = CLR;
    cmd_hold = 4'd0;
    k = int'(s);
    @(negedge clk);
    cmd_op   = SET;
    cmd_hold = 4'd0;
    k += int'(s);
    t = 0;
    while (k < 2 && t < 10) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k += int'(s);
      t++;
    end
    chk("t6_s_on", int'(s), 1);
    #2 reset = 1'b1;
    #1 chk("t6_async",
           {s, r, busy, cmd_ready}, 4'b0001);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    pq.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_nopulse", pq.size(), 0);
    chk("t6_idle", {s, r, busy}, 3'b000);

    // recovery after reset
    pq.delete();
    add(CLR, 4'd3);
    run();
    chk("t7_cnt", pq.size(), 1);
    chk_p("t7", 0, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
